// File: rtl/control_acceso_pin.sv
// control_acceso_pin
//   PIN-entry access controller. After an access request it collects
//   N_DIGITOS strobed digits (first digit = MSB digit of the key), compares
//   the full captured key against CLAVE and raises a timed accept or deny
//   pulse. Stalled entries time out as a forced failure. MAX_INTENTOS
//   consecutive failures start a timed lockout with alarm.
//
// Ports
//   CLK                in  clock, rising edge
//   RESET_N            in  asynchronous active-low reset
//   SOLICITUD_ACCESO   in  starts an entry when idle
//   DIGITO_STB         in  one-cycle strobe qualifying DIGITO
//   DIGITO             in  digit value [ANCHO_DIGITO]
//   ACCESO_ACEPTADO    out correct PIN pulse (CICLOS_SALIDA cycles)
//   ACCESO_DENEGADO    out wrong PIN / timeout / lockout
//   BLOQUEADO          out lockout active
//   ALARMA             out lockout alarm
//   INTENTOS_FALLIDOS  out consecutive failures so far
module control_acceso_pin #(
    parameter int unsigned N_DIGITOS      = 4,
    parameter int unsigned ANCHO_DIGITO   = 4,
    parameter logic [N_DIGITOS*ANCHO_DIGITO-1:0] CLAVE = 16'h6969,
    parameter int unsigned MAX_INTENTOS   = 3,
    parameter int unsigned TIMEOUT_CICLOS = 16,
    parameter int unsigned CICLOS_SALIDA  = 2,
    parameter int unsigned CICLOS_BLOQUEO = 32
) (
    input  logic                              CLK,
    input  logic                              RESET_N,
    input  logic                              SOLICITUD_ACCESO,
    input  logic                              DIGITO_STB,
    input  logic [ANCHO_DIGITO-1:0]           DIGITO,
    output logic                              ACCESO_ACEPTADO,
    output logic                              ACCESO_DENEGADO,
    output logic                              BLOQUEADO,
    output logic                              ALARMA,
    output logic [$clog2(MAX_INTENTOS+1)-1:0] INTENTOS_FALLIDOS
);

    localparam int unsigned AK = N_DIGITOS * ANCHO_DIGITO;
    localparam int unsigned IW = (N_DIGITOS > 1) ? $clog2(N_DIGITOS) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CICLOS + 1);
    localparam int unsigned SW = $clog2(CICLOS_SALIDA + 1);
    localparam int unsigned BW = $clog2(CICLOS_BLOQUEO + 1);
    localparam int unsigned FW = $clog2(MAX_INTENTOS + 1);

    typedef enum logic [2:0] {
        ESPERA   = 3'd0,
        INGRESO  = 3'd1,
        VERIFICA = 3'd2,
        ACEPTADO = 3'd3,
        DENEGADO = 3'd4,
        BLOQUEO  = 3'd5
    } estado_t;

    estado_t         estado;
    estado_t         estado_sig;
    logic [AK-1:0]   clave_cap;
    logic [IW-1:0]   indice;
    logic [TW-1:0]   cnt_to;
    logic            forzado;
    logic [SW-1:0]   cnt_sal;
    logic [BW-1:0]   cnt_blq;
    logic [FW-1:0]   intentos_inc;

    logic ultimo_digito;
    logic fin_to;
    logic fin_sal;
    logic fin_blq;
    logic coincide;
    logic limite;

    assign ultimo_digito = (indice == IW'(N_DIGITOS - 1));
    assign fin_to        = (cnt_to == TW'(TIMEOUT_CICLOS - 1));
    assign fin_sal       = (cnt_sal == SW'(CICLOS_SALIDA - 1));
    assign fin_blq       = (cnt_blq == BW'(CICLOS_BLOQUEO - 1));
    assign coincide      = (clave_cap == CLAVE);
    assign intentos_inc  = INTENTOS_FALLIDOS + FW'(1);
    assign limite        = (intentos_inc == FW'(MAX_INTENTOS));

    always_comb begin
        estado_sig = estado;
        case (estado)
            ESPERA:   if (SOLICITUD_ACCESO) estado_sig = INGRESO;
            INGRESO: begin
                if (DIGITO_STB) begin
                    if (ultimo_digito) estado_sig = VERIFICA;
                end else if (fin_to) begin
                    estado_sig = VERIFICA;
                end
            end
            VERIFICA: begin
                if (coincide && !forzado) estado_sig = ACEPTADO;
                else if (limite)          estado_sig = BLOQUEO;
                else                      estado_sig = DENEGADO;
            end
            ACEPTADO, DENEGADO: if (fin_sal) estado_sig = ESPERA;
            BLOQUEO:  if (fin_blq) estado_sig = ESPERA;
            default:  estado_sig = ESPERA;
        endcase
    end

    // Outputs are registered from the next state so they change on the same
    // edge as the state register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            estado            <= ESPERA;
            clave_cap         <= '0;
            indice            <= '0;
            cnt_to            <= '0;
            forzado           <= 1'b0;
            cnt_sal           <= '0;
            cnt_blq           <= '0;
            INTENTOS_FALLIDOS <= '0;
            ACCESO_ACEPTADO   <= 1'b0;
            ACCESO_DENEGADO   <= 1'b0;
            BLOQUEADO         <= 1'b0;
            ALARMA            <= 1'b0;
        end else begin
            estado          <= estado_sig;
            ACCESO_ACEPTADO <= (estado_sig == ACEPTADO);
            ACCESO_DENEGADO <= (estado_sig == DENEGADO) || (estado_sig == BLOQUEO);
            BLOQUEADO       <= (estado_sig == BLOQUEO);
            ALARMA          <= (estado_sig == BLOQUEO);

            case (estado)
                ESPERA: begin
                    if (SOLICITUD_ACCESO) begin
                        indice    <= '0;
                        clave_cap <= '0;
                        cnt_to    <= '0;
                        forzado   <= 1'b0;
                    end
                end
                INGRESO: begin
                    if (DIGITO_STB) begin
                        // Index 0 lands in the most significant digit slot.
                        clave_cap[(N_DIGITOS - 1 - int'(indice)) * ANCHO_DIGITO +: ANCHO_DIGITO] <= DIGITO;
                        if (!ultimo_digito) indice <= indice + IW'(1);
                        cnt_to <= '0;
                    end else if (fin_to) begin
                        forzado <= 1'b1;
                        cnt_to  <= TW'(TIMEOUT_CICLOS);
                    end else begin
                        cnt_to <= cnt_to + TW'(1);
                    end
                end
                VERIFICA: begin
                    cnt_sal <= '0;
                    cnt_blq <= '0;
                    if (coincide && !forzado)
                        INTENTOS_FALLIDOS <= '0;
                    else if (INTENTOS_FALLIDOS != FW'(MAX_INTENTOS))
                        INTENTOS_FALLIDOS <= intentos_inc;
                end
                ACEPTADO, DENEGADO: begin
                    if (!fin_sal) cnt_sal <= cnt_sal + SW'(1);
                end
                BLOQUEO: begin
                    if (fin_blq) INTENTOS_FALLIDOS <= '0;
                    else         cnt_blq <= cnt_blq + BW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
